// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for an N-digit common 7-segment display.
//   Packed BCD digits are captured into a shadow register only at frame
//   boundaries, so a frame never mixes old and new values. Each digit slot
//   lasts SCAN_DIV clocks. The first clock of every slot is a dead cycle
//   with everything off, which prevents ghosting while the anodes switch.
//   Leading zeros, blinking digits and invalid BCD codes are blanked.
//   Polarity inversion is applied last, and reset values follow it.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   digits_in   packed BCD, digit k in bits [4k+3:4k], digit 0 least significant
//   load        request to capture digits_in at the next frame boundary
//   blank_lz    enable leading-zero suppression
//   blink_en    enable blinking of digits selected by blink_mask
//   blink_mask  1 = digit k blinks
//   seg         segments {a,b,c,d,e,f,g}, a is the MSB
//   an          one-hot digit select
//   frame_done  one-clock pulse at the end of each frame
module seg7_scan_driver #(
   parameter int N_DIGITS       = 3,
   parameter int SCAN_DIV       = 1000,
   parameter int BLINK_FRAMES   = 250,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*N_DIGITS-1:0]   digits_in,
   input  logic                    load,
   input  logic                    blank_lz,
   input  logic                    blink_en,
   input  logic [N_DIGITS-1:0]     blink_mask,
   output logic [6:0]              seg,
   output logic [N_DIGITS-1:0]     an,
   output logic                    frame_done
);

   localparam int DIV_W  = $clog2(SCAN_DIV);
   localparam int SLOT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(N_DIGITS - 1);
   localparam logic [FRM_W-1:0]    FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);
   localparam logic [6:0]          SEG_INV   = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
   localparam logic [N_DIGITS-1:0] AN_INV    = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1111110;
         4'd1:    return 7'b0110000;
         4'd2:    return 7'b1101101;
         4'd3:    return 7'b1111001;
         4'd4:    return 7'b0110011;
         4'd5:    return 7'b1011011;
         4'd6:    return 7'b1011111;
         4'd7:    return 7'b1110000;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1110011;
         default: return 7'b0000000;
      endcase
   endfunction

   logic [4*N_DIGITS-1:0] shadow;
   logic                  pending;
   logic [DIV_W-1:0]      div_cnt;
   logic [SLOT_W-1:0]     slot;
   logic [FRM_W-1:0]      frame_cnt;
   logic                  phase_hidden;

   logic [3:0]            digit_arr [N_DIGITS];
   logic [N_DIGITS-1:0]   lz;
   logic [N_DIGITS-1:0]   an_sel;
   logic                  still_zero;
   logic                  tc;
   logic                  boundary;
   logic                  off;
   logic [6:0]            seg_next;
   logic [N_DIGITS-1:0]   an_next;

   always_comb begin
      for (int i = 0; i < N_DIGITS; i++) begin
         digit_arr[i] = shadow[4*i +: 4];
      end
   end

   // Scan from the most significant digit down; a digit is a leading zero
   // while every digit above it (and itself) is zero. Digit 0 always shows.
   always_comb begin
      lz         = '0;
      still_zero = 1'b1;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         still_zero = still_zero & (digit_arr[i] == 4'd0);
         lz[i]      = still_zero & (i != 0);
      end
   end

   always_comb begin
      an_sel       = '0;
      an_sel[slot] = 1'b1;
   end

   assign tc       = (div_cnt == DIV_LAST);
   assign boundary = tc && (slot == '0);

   // Dead cycle, leading-zero blanking and blink blanking all turn the
   // whole slot off, anode included.
   assign off = (div_cnt == '0)
              || (blank_lz && lz[slot])
              || (blink_en && phase_hidden && blink_mask[slot]);

   assign seg_next = off ? 7'b0000000 : seg_decode(digit_arr[slot]);
   assign an_next  = off ? '0 : an_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow       <= '0;
         pending      <= 1'b0;
         div_cnt      <= '0;
         slot         <= SLOT_LAST;
         frame_cnt    <= '0;
         phase_hidden <= 1'b0;
         seg          <= SEG_INV;
         an           <= AN_INV;
         frame_done   <= 1'b0;
      end else begin
         if (tc) begin
            div_cnt <= '0;
            slot    <= (slot == '0) ? SLOT_LAST : slot - 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end

         // A load arriving on the boundary cycle itself is captured directly.
         if (boundary) begin
            pending <= 1'b0;
            if (pending || load) begin
               shadow <= digits_in;
            end
            if (frame_cnt == FRM_LAST) begin
               frame_cnt    <= '0;
               phase_hidden <= ~phase_hidden;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end else if (load) begin
            pending <= 1'b1;
         end

         seg        <= seg_next ^ SEG_INV;
         an         <= an_next ^ AN_INV;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [11:0] digits_in = '0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic        blink_en = 1'b0;
   logic [2:0]  blink_mask = '0;
   logic [6:0]  seg_a, seg_b;
   logic [2:0]  an_a, an_b;
   logic        fd_a, fd_b;

   int checks = 0;
   int errors = 0;
   int frame_idx = 0;

   seg7_scan_driver #(
      .N_DIGITS(3), .SCAN_DIV(4), .BLINK_FRAMES(2),
      .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
      .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
      .seg(seg_a), .an(an_a), .frame_done(fd_a)
   );

   seg7_scan_driver #(
      .N_DIGITS(3), .SCAN_DIV(4), .BLINK_FRAMES(2),
      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
      .blank_lz(blank_lz), .blink_en(blink_en), .blink_mask(blink_mask),
      .seg(seg_b), .an(an_b), .frame_done(fd_b)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] seg;
      logic [2:0] an;
      logic       fd;
   } exp_t;

   typedef struct {
      logic [11:0] digits;
      logic        blz;
      logic [6:0]  s2, s1, s0;
      logic [2:0]  on;
   } vec_t;

   exp_t q[$];
   vec_t vecs[6];

   localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
   localparam logic [6:0] S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011;
   localparam logic [6:0] S7 = 7'b1110000, S8 = 7'b1111111, S9 = 7'b1110011;
   localparam logic [6:0] SOFF = 7'b0000000;

   task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got seg/an/fd=%b required %b", name, act, exp);
      end
   endtask

   // Check both DUTs against one logical expectation; the inverted DUT
   // must show the complement of seg and an with the same frame_done.
   task automatic check_both(input string name, input exp_t e);
      check({name, " A"}, {seg_a, an_a, fd_a}, e);
      check({name, " B"}, {seg_b, an_b, fd_b}, {~e.seg, ~e.an, e.fd});
   endtask

   // Called aligned to a frame start; runs one 12-clock frame. If load_at
   // is nonzero, load is raised after that output cycle for one clock.
   task automatic expect_frame(input logic [6:0] s2, input logic [6:0] s1,
                               input logic [6:0] s0, input logic [2:0] on,
                               input int load_at, input string tag);
      logic [6:0] sv [3];
      exp_t e;
      sv[0] = s0; sv[1] = s1; sv[2] = s2;
      for (int k = 2; k >= 0; k--) begin
         q.push_back('{seg: SOFF, an: 3'b000, fd: 1'b0});
         for (int j = 0; j < 3; j++) begin
            e.seg = sv[k];
            e.an  = on[k] ? (3'b001 << k) : 3'b000;
            e.fd  = (k == 0) && (j == 2);
            q.push_back(e);
         end
      end
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk);
         #1;
         e = q.pop_front();
         check_both($sformatf("%s f%0d c%0d", tag, frame_idx, i), e);
         load = (i == load_at);
      end
      load = 1'b0;
      frame_idx++;
   endtask

   initial begin
      logic [6:0] p2, p1, p0;
      logic [2:0] pon;
      logic       hidden;

      vecs[0] = '{12'h530, 1'b0, S5,   S3,   S0,   3'b111};
      vecs[1] = '{12'h007, 1'b1, SOFF, SOFF, S7,   3'b001};
      vecs[2] = '{12'h000, 1'b1, SOFF, SOFF, S0,   3'b001};
      vecs[3] = '{12'h040, 1'b1, SOFF, S4,   S0,   3'b011};
      vecs[4] = '{12'h0B0, 1'b0, S0,   SOFF, S0,   3'b111};
      vecs[5] = '{12'h888, 1'b0, S8,   S8,   S8,   3'b111};

      // Reset held for 5 clocks while load toggles; outputs stay at reset values.
      #1 rst_n = 1'b0;
      digits_in = 12'h357;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         load = ~load;
         check_both($sformatf("reset c%0d", i), '{seg: SOFF, an: 3'b000, fd: 1'b0});
      end
      load = 1'b0;
      rst_n = 1'b1;
      frame_idx = 0;

      expect_frame(S0, S0, S0, 3'b111, 0, "post_reset");

      // Each vector: loaded mid-frame (old value must hold), shown next frame.
      p2 = S0; p1 = S0; p0 = S0; pon = 3'b111;
      for (int r = 0; r < 6; r++) begin
         digits_in = vecs[r].digits;
         expect_frame(p2, p1, p0, pon, 5, $sformatf("vec%0d old", r));
         blank_lz = vecs[r].blz;
         expect_frame(vecs[r].s2, vecs[r].s1, vecs[r].s0, vecs[r].on, 0,
                      $sformatf("vec%0d new", r));
         p2 = vecs[r].s2; p1 = vecs[r].s1; p0 = vecs[r].s0; pon = vecs[r].on;
      end

      // Load only on the boundary cycle; digits_in changes right after it.
      digits_in = 12'h921;
      expect_frame(p2, p1, p0, pon, 11, "bnd old");
      digits_in = 12'h456;
      expect_frame(S9, S2, S1, 3'b111, 0, "bnd new");
      expect_frame(S9, S2, S1, 3'b111, 0, "bnd hold");

      // Blink digit 0: phase flips every 2 frames counted from reset.
      blink_en = 1'b1;
      blink_mask = 3'b001;
      for (int f = 0; f < 6; f++) begin
         hidden = ((frame_idx / 2) % 2) == 1;
         expect_frame(S9, S2, hidden ? SOFF : S1, hidden ? 3'b110 : 3'b111, 0,
                      hidden ? "blink hid" : "blink vis");
      end
      blink_en = 1'b0;
      for (int f = 0; f < 2; f++) begin
         expect_frame(S9, S2, S1, 3'b111, 0, "blink off");
      end

      // Asynchronous reset mid-frame with a pending load that must be lost.
      digits_in = 12'h777;
      load = 1'b1;
      @(posedge clk);
      #1 load = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_both("async reset", '{seg: SOFF, an: 3'b000, fd: 1'b0});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_both($sformatf("async hold c%0d", i), '{seg: SOFF, an: 3'b000, fd: 1'b0});
      end
      rst_n = 1'b1;
      frame_idx = 0;
      expect_frame(S0, S0, S0, 3'b111, 0, "rst2 f0");
      expect_frame(S0, S0, S0, 3'b111, 0, "rst2 f1");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
